// File: rtl/imu_axis_filter_pkg.sv
// imu_axis_filter_pkg: shared state encoding and axis constants for the IMU axis filter
package imu_axis_filter_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;
  localparam int NUM_AXES = 6;
  localparam int ACCEL_SHIFT = 4;
  localparam logic [2:0] AX_ACL_X = 3'd0;
  localparam logic [2:0] AX_ACL_Y = 3'd1;
  localparam logic [2:0] AX_ACL_Z = 3'd2;
  localparam logic [2:0] AX_MAG_X = 3'd3;
  localparam logic [2:0] AX_MAG_Y = 3'd4;
  localparam logic [2:0] AX_MAG_Z = 3'd5;
endpackage

// File: rtl/imu_axis_accum.sv
// imu_axis_accum: six-entry accumulator bank with one shared adder and floor-shifted readout
module imu_axis_accum
  import imu_axis_filter_pkg::*;
#(
  parameter int ACC_W = 21,
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add_en,
  input  logic [2:0]               idx,
  input  logic [ACC_W-1:0]         sample,
  output logic [NUM_AXES*32-1:0]   shr
);
  logic signed [ACC_W-1:0] acc [NUM_AXES];
  logic signed [ACC_W-1:0] sum;
  assign sum = acc[idx] + $signed(sample);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_AXES; i++) acc[i] <= '0;
    else if (clr) for (int i = 0; i < NUM_AXES; i++) acc[i] <= '0;
    else if (add_en) acc[idx] <= sum;
  for (genvar g = 0; g < NUM_AXES; g++) begin : g_shr
    logic signed [ACC_W-1:0] sh;
    assign sh = acc[g] >>> AVG_LOG2;
    assign shr[g*32 +: 32] = 32'(sh);
  end
endmodule

// File: rtl/imu_axis_filter.sv
// imu_axis_filter: snapshots six-axis frames and box-car averages each axis over 2^AVG_LOG2 frames
module imu_axis_filter
  import imu_axis_filter_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int ACC_W = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [31:0] acl_x,
  input  logic [31:0] acl_y,
  input  logic [31:0] acl_z,
  input  logic [31:0] mag_x,
  input  logic [31:0] mag_y,
  input  logic [31:0] mag_z,
  input  logic        clear,
  output logic [31:0] avg_acl_x,
  output logic [31:0] avg_acl_y,
  output logic [31:0] avg_acl_z,
  output logic [31:0] avg_mag_x,
  output logic [31:0] avg_mag_y,
  output logic [31:0] avg_mag_z,
  output logic        out_valid,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  state_t state;
  logic [NUM_AXES*16-1:0] snap;
  logic [NUM_AXES*32-1:0] avg_q, shr;
  logic [2:0] idx;
  logic [AVG_LOG2:0] frame_cnt, cnt_nxt;
  logic signed [15:0] w, s16;
  logic [ACC_W-1:0] sample;
  assign w = snap[idx*16 +: 16];
  assign s16 = (idx < AX_MAG_X) ? w >>> ACCEL_SHIFT : w;
  assign sample = ACC_W'(s16);
  // top bit of the incremented count is set exactly when the window fills
  assign cnt_nxt = frame_cnt + 1'b1;
  imu_axis_accum #(.ACC_W(ACC_W), .AVG_LOG2(AVG_LOG2)) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clear || state == PUBLISH),
    .add_en (state == ACCUM && !clear),
    .idx    (idx),
    .sample (sample),
    .shr    (shr)
  );
  assign avg_acl_x = avg_q[AX_ACL_X*32 +: 32];
  assign avg_acl_y = avg_q[AX_ACL_Y*32 +: 32];
  assign avg_acl_z = avg_q[AX_ACL_Z*32 +: 32];
  assign avg_mag_x = avg_q[AX_MAG_X*32 +: 32];
  assign avg_mag_y = avg_q[AX_MAG_Y*32 +: 32];
  assign avg_mag_z = avg_q[AX_MAG_Z*32 +: 32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      frame_cnt <= '0;
      avg_q <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      drop_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        state <= IDLE;
        frame_cnt <= '0;
        idx <= '0;
        busy <= 1'b0;
      end else begin
        if (frame_valid && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        case (state)
          IDLE: if (frame_valid) begin
            snap <= {mag_z[15:0], mag_y[15:0], mag_x[15:0], acl_z[15:0], acl_y[15:0], acl_x[15:0]};
            idx <= '0;
            busy <= 1'b1;
            state <= ACCUM;
          end
          ACCUM: begin
            idx <= (idx == AX_MAG_Z) ? 3'd0 : idx + 3'd1;
            if (idx == AX_MAG_Z) begin
              busy <= 1'b0;
              frame_cnt <= cnt_nxt;
              state <= cnt_nxt[AVG_LOG2] ? PUBLISH : IDLE;
            end
          end
          PUBLISH: begin
            avg_q <= shr;
            out_valid <= 1'b1;
            frame_cnt <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_imu_axis_filter.sv
// tb_imu_axis_filter: directed tests of averaging, rounding, drops, clear and reset for imu_axis_filter
module tb_imu_axis_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_valid = 1'b0;
  logic clear = 1'b0;
  logic [31:0] acl_x = '0, acl_y = '0, acl_z = '0, mag_x = '0, mag_y = '0, mag_z = '0;
  logic [31:0] avg_acl_x, avg_acl_y, avg_acl_z, avg_mag_x, avg_mag_y, avg_mag_z;
  logic [31:0] avg0_acl_x, avg0_acl_y, avg0_acl_z, avg0_mag_x, avg0_mag_y, avg0_mag_z;
  logic out_valid, busy, out_valid0, busy0;
  logic [7:0] drop_cnt, drop_cnt0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imu_axis_filter #(.AVG_LOG2(2), .ACC_W(21)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
    .acl_x(acl_x), .acl_y(acl_y), .acl_z(acl_z), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .clear(clear),
    .avg_acl_x(avg_acl_x), .avg_acl_y(avg_acl_y), .avg_acl_z(avg_acl_z),
    .avg_mag_x(avg_mag_x), .avg_mag_y(avg_mag_y), .avg_mag_z(avg_mag_z),
    .out_valid(out_valid), .busy(busy), .drop_cnt(drop_cnt)
  );

  imu_axis_filter #(.AVG_LOG2(0), .ACC_W(17)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
    .acl_x(acl_x), .acl_y(acl_y), .acl_z(acl_z), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .clear(clear),
    .avg_acl_x(avg0_acl_x), .avg_acl_y(avg0_acl_y), .avg_acl_z(avg0_acl_z),
    .avg_mag_x(avg0_mag_x), .avg_mag_y(avg0_mag_y), .avg_mag_z(avg0_mag_z),
    .out_valid(out_valid0), .busy(busy0), .drop_cnt(drop_cnt0)
  );

  task automatic send(input logic [15:0] ax, ay, az, mx, my, mz);
    acl_x = {16'h0, ax}; acl_y = {16'h0, ay}; acl_z = {16'h0, az};
    mag_x = {16'h0, mx}; mag_y = {16'h0, my}; mag_z = {16'h0, mz};
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  // one accepted frame plus 9 observed cycles, so back-to-back calls space frames 10 cycles apart
  task automatic run_frame(input logic [15:0] ax, ay, az, mx, my, mz,
                           output int pulses, output int at, output logic [9:0] mask, output int pulses0);
    pulses = 0; at = -1; pulses0 = 0; mask = '0;
    send(ax, ay, az, mx, my, mz);
    mask[0] = busy;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      mask[k] = busy;
      if (out_valid) begin pulses++; at = k; end
      if (out_valid0) pulses0++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    vectors++; if (avg_acl_x !== 32'h0) begin miscompares++; $display("FAIL reset_avg_acl_x: got %h want 00000000", avg_acl_x); end
    vectors++; if (avg_mag_z !== 32'h0) begin miscompares++; $display("FAIL reset_avg_mag_z: got %h want 00000000", avg_mag_z); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int p, a, p0, early;
    logic [9:0] m;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      run_frame(16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFF6, p, a, m, p0);
      if (i < 3) early += p;
      if (i == 0) begin
        vectors++; if (m !== 10'h03F) begin miscompares++; $display("FAIL basic_busy_window: got %h want 03f", m); end
        vectors++; if (avg0_acl_x !== 32'h10) begin miscompares++; $display("FAIL basic_win1_acl_x: got %h want 00000010", avg0_acl_x); end
        vectors++; if (p0 !== 1) begin miscompares++; $display("FAIL basic_win1_pulses: got %0d want 1", p0); end
      end
    end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL basic_early_valid: got %0d want 0", early); end
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL basic_pulses: got %0d want 1", p); end
    vectors++; if (a !== 7) begin miscompares++; $display("FAIL basic_latency: got %0d want 7", a); end
    vectors++; if (m !== 10'h03F) begin miscompares++; $display("FAIL basic_busy_last: got %h want 03f", m); end
    vectors++; if (avg_acl_x !== 32'h00000010) begin miscompares++; $display("FAIL basic_avg_acl_x: got %h want 00000010", avg_acl_x); end
    vectors++; if (avg_mag_z !== 32'hFFFFFFF6) begin miscompares++; $display("FAIL basic_avg_mag_z: got %h want fffffff6", avg_mag_z); end
    vectors++; if (avg_acl_y !== 32'h0) begin miscompares++; $display("FAIL basic_avg_acl_y: got %h want 00000000", avg_acl_y); end
  endtask

  task automatic test_rounding;
    int p, a, p0;
    logic [9:0] m;
    run_frame(16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, p, a, m, p0);
    vectors++; if (avg0_mag_x !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL round_win1_mag_x: got %h want ffffffff", avg0_mag_x); end
    for (int i = 0; i < 3; i++) run_frame(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, p, a, m, p0);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL round_pulses: got %0d want 1", p); end
    vectors++; if (avg_mag_x !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL round_avg_mag_x: got %h want ffffffff", avg_mag_x); end
    vectors++; if (avg_acl_x !== 32'h0) begin miscompares++; $display("FAIL round_avg_acl_x: got %h want 00000000", avg_acl_x); end
    vectors++; if (avg_mag_z !== 32'h0) begin miscompares++; $display("FAIL round_avg_mag_z: got %h want 00000000", avg_mag_z); end
  endtask

  task automatic test_drop;
    int p, a, p0, early;
    logic [9:0] m;
    early = 0;
    send(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    send(16'h0, 16'h0, 16'h7FF0, 16'h0, 16'h0, 16'h0);
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL drop_cnt_one: got %0d want 1", drop_cnt); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got %b want 1", busy); end
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      run_frame(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h0, p, a, m, p0);
      if (i < 2) early += p;
    end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL drop_window_count: got %0d pulses want 0", early); end
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL drop_pulses: got %0d want 1", p); end
    vectors++; if (avg_acl_z !== 32'h2) begin miscompares++; $display("FAIL drop_avg_acl_z: got %h want 00000002", avg_acl_z); end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL drop_cnt_hold: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_saturation;
    acl_x = '0; acl_y = '0; acl_z = '0; mag_x = '0; mag_y = '0; mag_z = '0;
    frame_valid = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    frame_valid = 1'b0;
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
    vectors++; if (drop_cnt0 !== 8'd255) begin miscompares++; $display("FAIL sat_drop_cnt0: got %0d want 255", drop_cnt0); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_clear;
    int p, a, p0, early;
    logic [9:0] m;
    early = 0;
    clear = 1'b1;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    frame_valid = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_priority_busy: got %b want 0", busy); end
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL clear_drop_cnt: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 2; i++) begin
      run_frame(16'h0, 16'h7FF0, 16'h0, 16'h0, 16'h0, 16'h0, p, a, m, p0);
      early += p;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_frame(16'h0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, p, a, m, p0);
      if (i < 3) early += p;
    end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL clear_early_valid: got %0d want 0", early); end
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL clear_pulses: got %0d want 1", p); end
    vectors++; if (avg_acl_y !== 32'h1) begin miscompares++; $display("FAIL clear_avg_acl_y: got %h want 00000001", avg_acl_y); end
  endtask

  task automatic test_reset_mid;
    int p, a, p0, early;
    logic [9:0] m;
    early = 0;
    send(16'h7FF0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (avg_acl_y !== 32'h0) begin miscompares++; $display("FAIL rst_mid_avg_acl_y: got %h want 00000000", avg_acl_y); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_mid_drop_cnt: got %0d want 0", drop_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_frame(16'h0030, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, p, a, m, p0);
      if (i < 3) early += p;
    end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL rst_mid_early_valid: got %0d want 0", early); end
    vectors++; if (a !== 7) begin miscompares++; $display("FAIL rst_mid_latency: got %0d want 7", a); end
    vectors++; if (avg_acl_x !== 32'h3) begin miscompares++; $display("FAIL rst_mid_avg_acl_x: got %h want 00000003", avg_acl_x); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_drop();
    test_saturation();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
